// File: rtl/counter_sequencer.sv
// ---------------------------------------------------------------------------
// counter_sequencer
//
// Run/pause/step controller for an up/down display counter. Counting is
// paced by a clock-enable tick from an internal prescaler; there is no
// derived clock. A four-state FSM (IDLE/RUN/PAUSE/DONE) sequences free-run,
// single-step, load and run-to-target operation.
//
// Ports:
//   clk           system clock (only clock)
//   rst           synchronous, active-high reset
//   start_i       pulse: begin/resume counting
//   stop_i        pulse: abort to IDLE (count retained)
//   pause_i       pulse: freeze in PAUSE
//   step_i        pulse: single +/-1 step when not running
//   load_i        pulse: load load_value_i (clamped to MAX_VAL)
//   load_value_i  value for load
//   target_i      stop value for run-to-target mode
//   mode_i        0 = free-run with wrap, 1 = run-to-target
//   reverse_i     0 = count up, 1 = count down
//   count_o       current count
//   state_o       IDLE=00, RUN=01, PAUSE=10, DONE=11
//   busy_o        high while in RUN
//   done_o        one-cycle pulse on entry to DONE
//   tick_o        prescaler tick (RUN only)
// ---------------------------------------------------------------------------
module counter_sequencer #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 25,
    parameter int MAX_VAL  = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             pause_i,
    input  logic             step_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic [WIDTH-1:0] target_i,
    input  logic             mode_i,
    input  logic             reverse_i,
    output logic [WIDTH-1:0] count_o,
    output logic [1:0]       state_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             tick_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] MAX_C      = WIDTH'(MAX_VAL);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    // Single winning command per cycle after priority resolution.
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_STOP,
        CMD_LOAD,
        CMD_PAUSE,
        CMD_START,
        CMD_STEP
    } cmd_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [PW-1:0]    r_presc, w_presc_nxt;
    logic             r_done,  w_done_nxt;

    cmd_t             w_cmd;
    logic             w_tick;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_load_val;
    logic             w_hit;

    // Priority: stop > load > pause > start > step. The losers are dropped
    // even when the winner turns out to be ignored in the current state.
    always_comb begin
        w_cmd = CMD_NONE;
        if (stop_i)       w_cmd = CMD_STOP;
        else if (load_i)  w_cmd = CMD_LOAD;
        else if (pause_i) w_cmd = CMD_PAUSE;
        else if (start_i) w_cmd = CMD_START;
        else if (step_i)  w_cmd = CMD_STEP;
    end

    assign w_tick = (r_state == S_RUN) && (r_presc == PRESC_LAST);

    // Wrapping +/-1 inside 0..MAX_VAL.
    always_comb begin
        if (reverse_i)
            w_step_val = (r_count == '0) ? MAX_C : r_count - WIDTH'(1);
        else
            w_step_val = (r_count == MAX_C) ? '0 : r_count + WIDTH'(1);
    end

    assign w_load_val = (load_value_i > MAX_C) ? MAX_C : load_value_i;
    assign w_hit      = mode_i && (w_step_val == target_i);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can
        // leave one unassigned, which would infer a latch.
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_presc_nxt = '0;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                unique case (w_cmd)
                    CMD_START: w_state_nxt = S_RUN;
                    CMD_LOAD:  w_count_nxt = w_load_val;
                    CMD_STEP:  w_count_nxt = w_step_val;
                    default:   ;
                endcase
            end

            S_RUN: begin
                if (w_cmd == CMD_STOP) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cmd == CMD_PAUSE) begin
                    // Prescaler restarts from 0 on resume; partial interval lost.
                    w_state_nxt = S_PAUSE;
                end else if (w_tick) begin
                    w_count_nxt = w_step_val;
                    if (w_hit) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_presc_nxt = r_presc + PW'(1);
                end
            end

            S_PAUSE: begin
                unique case (w_cmd)
                    CMD_STOP:  w_state_nxt = S_IDLE;
                    CMD_LOAD:  w_count_nxt = w_load_val;
                    CMD_START: w_state_nxt = S_RUN;
                    CMD_STEP: begin
                        w_count_nxt = w_step_val;
                        if (w_hit) begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                    default:   ;
                endcase
            end

            S_DONE: begin
                unique case (w_cmd)
                    CMD_STOP: w_state_nxt = S_IDLE;
                    CMD_LOAD: begin
                        w_count_nxt = w_load_val;
                        w_state_nxt = S_IDLE;
                    end
                    default:  ;
                endcase
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_presc <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_presc <= w_presc_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign count_o = r_count;
    assign state_o = r_state;
    assign busy_o  = (r_state == S_RUN);
    assign done_o  = r_done;
    assign tick_o  = w_tick;

endmodule

// File: tb/tb_counter_sequencer.sv
// ---------------------------------------------------------------------------
// tb_counter_sequencer
//
// Directed bench for counter_sequencer with TICK_DIV=4, WIDTH=8, MAX_VAL=255.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_counter_sequencer;

    localparam int WIDTH    = 8;
    localparam int TICK_DIV = 4;
    localparam int MAX_VAL  = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i, stop_i, pause_i, step_i, load_i;
    logic [WIDTH-1:0] load_value_i, target_i;
    logic             mode_i, reverse_i;
    logic [WIDTH-1:0] count_o;
    logic [1:0]       state_o;
    logic             busy_o, done_o, tick_o;

    int total = 0;
    int bad   = 0;

    counter_sequencer #(
        .WIDTH    (WIDTH),
        .TICK_DIV (TICK_DIV),
        .MAX_VAL  (MAX_VAL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .pause_i      (pause_i),
        .step_i       (step_i),
        .load_i       (load_i),
        .load_value_i (load_value_i),
        .target_i     (target_i),
        .mode_i       (mode_i),
        .reverse_i    (reverse_i),
        .count_o      (count_o),
        .state_o      (state_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .tick_o       (tick_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle pulse on the selected controls; returns one falling edge later,
    // i.e. just after the rising edge that sampled the pulse.
    task automatic strobe(input logic s_start, input logic s_stop, input logic s_pause,
                          input logic s_step, input logic s_load);
        start_i = s_start;
        stop_i  = s_stop;
        pause_i = s_pause;
        step_i  = s_step;
        load_i  = s_load;
        cyc(1);
        start_i = 1'b0;
        stop_i  = 1'b0;
        pause_i = 1'b0;
        step_i  = 1'b0;
        load_i  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {start_i, stop_i, pause_i, step_i, load_i} = '0;
        load_value_i = '0;
        target_i     = '0;
        mode_i       = 1'b0;
        reverse_i    = 1'b0;

        // Reset
        cyc(3);
        check("rst_count", count_o, 0);
        check("rst_state", state_o, 2'b00);
        check("rst_busy",  busy_o,  0);
        check("rst_done",  done_o,  0);
        check("rst_tick",  tick_o,  0);
        rst = 1'b0;
        cyc(7);

        // Tick timing: first change TICK_DIV cycles after start
        strobe(1, 0, 0, 0, 0);
        check("run_state", state_o, 2'b01);
        check("run_busy",  busy_o,  1);
        cyc(3);
        check("tick1",     tick_o,  1);
        check("tick1_cnt", count_o, 0);
        cyc(1);
        check("cnt1",      count_o, 1);
        check("tick1_off", tick_o,  0);
        cyc(3);
        check("tick2",     tick_o,  1);
        cyc(1);
        check("cnt2",      count_o, 2);

        // Same-cycle stop+start: stop wins
        strobe(1, 1, 0, 0, 0);
        check("stopstart_state", state_o, 2'b00);
        check("stopstart_cnt",   count_o, 2);

        // Pause ignored in IDLE, step works in IDLE
        strobe(0, 0, 1, 0, 0);
        check("idle_pause_ign", state_o, 2'b00);
        strobe(0, 0, 0, 1, 0);
        check("idle_step", count_o, 3);

        // Up wrap
        load_value_i = 8'd254;
        strobe(0, 0, 0, 0, 1);
        check("load254", count_o, 254);
        strobe(1, 0, 0, 0, 0);
        cyc(4);
        check("up_255", count_o, 255);
        cyc(4);
        check("up_0",   count_o, 0);
        check("up_run", state_o, 2'b01);
        cyc(4);
        check("up_1",   count_o, 1);

        // Load ignored in RUN
        load_value_i = 8'd100;
        strobe(0, 0, 0, 0, 1);
        check("run_load_ign",   count_o, 1);
        check("run_load_state", state_o, 2'b01);
        strobe(0, 1, 0, 0, 0);
        check("stop_idle", state_o, 2'b00);
        check("stop_keep", count_o, 1);

        // Down wrap
        load_value_i = 8'd1;
        reverse_i    = 1'b1;
        strobe(0, 0, 0, 0, 1);
        strobe(1, 0, 0, 0, 0);
        cyc(4);
        check("dn_0",   count_o, 0);
        cyc(4);
        check("dn_255", count_o, 255);
        strobe(0, 1, 0, 0, 0);
        reverse_i = 1'b0;

        // Run-to-target
        load_value_i = 8'd5;
        strobe(0, 0, 0, 0, 1);
        target_i = 8'd8;
        mode_i   = 1'b1;
        strobe(1, 0, 0, 0, 0);
        cyc(4);
        check("tgt_6", count_o, 6);
        cyc(4);
        check("tgt_7", count_o, 7);
        cyc(3);
        check("tgt_pre_done", done_o, 0);
        cyc(1);
        check("tgt_8",     count_o, 8);
        check("tgt_done",  done_o,  1);
        check("tgt_state", state_o, 2'b11);
        check("tgt_busy",  busy_o,  0);
        cyc(1);
        check("tgt_done_pulse", done_o, 0);
        cyc(8);
        check("tgt_hold", count_o, 8);
        check("tgt_notick", tick_o, 0);
        strobe(1, 0, 0, 0, 0);
        check("done_start_ign", state_o, 2'b11);
        strobe(0, 1, 0, 0, 0);
        check("done_stop", state_o, 2'b00);
        check("done_stop_cnt", count_o, 8);

        // Start with count already on target: no immediate DONE
        strobe(1, 0, 0, 0, 0);
        check("attgt_run", state_o, 2'b01);
        cyc(4);
        check("attgt_9",   count_o, 9);
        check("attgt_run2", state_o, 2'b01);
        strobe(0, 1, 0, 0, 0);
        mode_i = 1'b0;

        // Pause / step / resume
        load_value_i = 8'd0;
        strobe(0, 0, 0, 0, 1);
        strobe(1, 0, 0, 0, 0);
        cyc(12);
        check("ps_3", count_o, 3);
        cyc(2);
        strobe(0, 0, 1, 0, 0);
        check("ps_state", state_o, 2'b10);
        check("ps_cnt",   count_o, 3);
        strobe(0, 0, 0, 1, 0);
        check("ps_step4", count_o, 4);
        strobe(0, 0, 0, 1, 0);
        check("ps_step5", count_o, 5);
        check("ps_still", state_o, 2'b10);
        strobe(1, 0, 0, 0, 0);
        check("ps_resume", state_o, 2'b01);
        cyc(3);
        check("ps_wait", count_o, 5);
        cyc(1);
        check("ps_6", count_o, 6);

        // Step in PAUSE landing on target; load in DONE returns to IDLE
        strobe(0, 0, 1, 0, 0);
        mode_i   = 1'b1;
        target_i = 8'd7;
        strobe(0, 0, 0, 1, 0);
        check("pstep_cnt",   count_o, 7);
        check("pstep_state", state_o, 2'b11);
        check("pstep_done",  done_o,  1);
        cyc(1);
        check("pstep_done_off", done_o, 0);
        load_value_i = 8'd42;
        strobe(0, 0, 0, 0, 1);
        check("done_load_state", state_o, 2'b00);
        check("done_load_cnt",   count_o, 42);
        mode_i = 1'b0;

        // Reset mid-RUN
        load_value_i = 8'd5;
        strobe(0, 0, 0, 0, 1);
        strobe(1, 0, 0, 0, 0);
        cyc(8);
        check("mid_7", count_o, 7);
        rst = 1'b1;
        cyc(1);
        check("mid_rst_cnt",   count_o, 0);
        check("mid_rst_state", state_o, 2'b00);
        check("mid_rst_busy",  busy_o,  0);
        check("mid_rst_tick",  tick_o,  0);
        rst = 1'b0;
        cyc(2);
        check("post_rst_idle", state_o, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
